// File: rtl/game_sequencer_if.sv
// Sequencer <-> datapath/render bundle: raw buttons and enemy status in, tick, phase and strobes out.
// master = the sequencer, slave = its consumers.
interface game_sequencer_if #(
    parameter int ENEMY_COUNT = 6
);
    logic                   btn_left_n;
    logic                   btn_right_n;
    logic [ENEMY_COUNT-1:0] enemy_alive;
    logic                   hit;

    logic                   tick;
    logic [1:0]             phase;
    logic                   play_en;
    logic [3:0]             player_pos;
    logic                   enemy_phase;
    logic                   explode_active;
    logic [1:0]             explode_frame;
    logic                   win_blink;

    modport master (
        input  btn_left_n, btn_right_n, enemy_alive, hit,
        output tick, phase, play_en, player_pos, enemy_phase,
               explode_active, explode_frame, win_blink
    );

    modport slave (
        output btn_left_n, btn_right_n, enemy_alive, hit,
        input  tick, phase, play_en, player_pos, enemy_phase,
               explode_active, explode_frame, win_blink
    );
endinterface

// File: rtl/game_sequencer.sv
// Game sequencer: tick divider, phase FSM, latched buttons, player column, explosion timer.
// All outputs registered; state moves on the edge that ends a tick cycle. No backpressure.
// Optional pause phase (both buttons at a tick) enabled by defining GAME_SEQUENCER_PAUSE_EN.
module game_sequencer #(
    parameter int TICK_DIV      = 20000000,
    parameter int START_TICKS   = 3,
    parameter int EXPLODE_TICKS = 3,
    parameter int ENEMY_COUNT   = 6,
    parameter int PLAYER_START  = 3
) (
    input  logic               CLK_50,
    input  logic               reset,
    game_sequencer_if.master   gs
);
    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int CD_W  = $clog2(START_TICKS + 2);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CD_W-1:0]  CD_START  = CD_W'(START_TICKS);
    localparam logic [3:0]       POS_MAX   = 4'(2 * ENEMY_COUNT - 1);
    localparam logic [3:0]       POS_START = 4'(PLAYER_START);
    localparam logic [1:0]       EXP_LAST  = 2'(EXPLODE_TICKS - 1);

    typedef enum logic [1:0] {
        COUNTDOWN = 2'd0,
        PLAY      = 2'd1,
        WIN       = 2'd2,
        PAUSE     = 2'd3
    } phase_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [CD_W-1:0]  countdown_q, countdown_d;
    logic [1:0]       sync_l_q, sync_l_d;
    logic [1:0]       sync_r_q, sync_r_d;
    logic             req_l_q, req_l_d;
    logic             req_r_q, req_r_d;
    phase_t           phase_q, phase_d;
    logic             play_en_q, play_en_d;
    logic [3:0]       pos_q, pos_d;
    logic             enemy_phase_q, enemy_phase_d;
    logic             win_blink_q, win_blink_d;
    logic             exp_act_q, exp_act_d;
    logic [1:0]       exp_frame_q, exp_frame_d;

    always_comb begin
        cnt_d  = (cnt_q == TICK_LAST) ? '0 : cnt_q + CNT_W'(1);
        tick_d = (cnt_d == TICK_LAST);

        sync_l_d = {sync_l_q[0], gs.btn_left_n};
        sync_r_d = {sync_r_q[0], gs.btn_right_n};

        // Flags are sampled by the FSM in the tick cycle; a press seen in that same cycle survives.
        req_l_d = tick_q ? ~sync_l_q[1] : (req_l_q | ~sync_l_q[1]);
        req_r_d = tick_q ? ~sync_r_q[1] : (req_r_q | ~sync_r_q[1]);

        phase_d       = phase_q;
        countdown_d   = countdown_q;
        pos_d         = pos_q;
        enemy_phase_d = enemy_phase_q;
        win_blink_d   = win_blink_q;

        if (tick_q) begin
            case (phase_q)
                COUNTDOWN: begin
                    if (countdown_q == '0) begin
                        phase_d = PLAY;
                    end else begin
                        countdown_d = countdown_q - CD_W'(1);
                    end
                end
                PLAY: begin
                    if (gs.enemy_alive == '0) begin
                        phase_d = WIN;
`ifdef GAME_SEQUENCER_PAUSE_EN
                    end else if (req_l_q && req_r_q) begin
                        phase_d = PAUSE;
`endif
                    end else begin
                        enemy_phase_d = ~enemy_phase_q;
                        // Right wins; a blocked request is dropped, never turned into the other direction.
                        if (req_r_q) begin
                            if (pos_q != POS_MAX) begin
                                pos_d = pos_q + 4'd1;
                            end
                        end else if (req_l_q) begin
                            if (pos_q != 4'd0) begin
                                pos_d = pos_q - 4'd1;
                            end
                        end
                    end
                end
                WIN: begin
                    win_blink_d = ~win_blink_q;
                end
                PAUSE: begin
`ifdef GAME_SEQUENCER_PAUSE_EN
                    if (req_l_q && req_r_q) begin
                        phase_d = PLAY;
                    end
`endif
                end
                default: begin
                    phase_d = phase_q;
                end
            endcase
        end

        play_en_d = (phase_d == PLAY);

        exp_act_d   = exp_act_q;
        exp_frame_d = exp_frame_q;
        if (gs.hit && play_en_q) begin
            exp_act_d   = 1'b1;
            exp_frame_d = 2'd0;
        end else if (tick_q && exp_act_q && (phase_q != PAUSE)) begin
            if (exp_frame_q == EXP_LAST) begin
                exp_act_d   = 1'b0;
                exp_frame_d = 2'd0;
            end else begin
                exp_frame_d = exp_frame_q + 2'd1;
            end
        end
    end

    always_ff @(posedge CLK_50) begin
        if (reset) begin
            cnt_q         <= '0;
            tick_q        <= 1'b0;
            countdown_q   <= CD_START;
            sync_l_q      <= 2'b11;
            sync_r_q      <= 2'b11;
            req_l_q       <= 1'b0;
            req_r_q       <= 1'b0;
            phase_q       <= COUNTDOWN;
            play_en_q     <= 1'b0;
            pos_q         <= POS_START;
            enemy_phase_q <= 1'b0;
            win_blink_q   <= 1'b1;
            exp_act_q     <= 1'b0;
            exp_frame_q   <= 2'd0;
        end else begin
            cnt_q         <= cnt_d;
            tick_q        <= tick_d;
            countdown_q   <= countdown_d;
            sync_l_q      <= sync_l_d;
            sync_r_q      <= sync_r_d;
            req_l_q       <= req_l_d;
            req_r_q       <= req_r_d;
            phase_q       <= phase_d;
            play_en_q     <= play_en_d;
            pos_q         <= pos_d;
            enemy_phase_q <= enemy_phase_d;
            win_blink_q   <= win_blink_d;
            exp_act_q     <= exp_act_d;
            exp_frame_q   <= exp_frame_d;
        end
    end

    assign gs.tick           = tick_q;
    assign gs.phase          = phase_q;
    assign gs.play_en        = play_en_q;
    assign gs.player_pos     = pos_q;
    assign gs.enemy_phase    = enemy_phase_q;
    assign gs.explode_active = exp_act_q;
    assign gs.explode_frame  = exp_frame_q;
    assign gs.win_blink      = win_blink_q;
endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer with TICK_DIV=4, START_TICKS=3, EXPLODE_TICKS=3, ENEMY_COUNT=6.
// Pause expectations follow GAME_SEQUENCER_PAUSE_EN.
module tb_game_sequencer;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   cyc;

    game_sequencer_if #(.ENEMY_COUNT(6)) gs_if ();

    game_sequencer #(
        .TICK_DIV      (4),
        .START_TICKS   (3),
        .EXPLODE_TICKS (3),
        .ENEMY_COUNT   (6),
        .PLAYER_START  (3)
    ) dut (
        .CLK_50 (clk),
        .reset  (reset),
        .gs     (gs_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance to the next tick cycle (bounded), then one cycle more so its effects are visible.
    task automatic run_tick();
        int k;
        k = 0;
        while (gs_if.tick !== 1'b1 && k < 16) begin
            next();
            k++;
        end
        check("tick_wait", {31'd0, gs_if.tick}, 32'd1);
        next();
    endtask

    // Called one cycle after a tick: one-cycle press, lands on the following tick.
    task automatic press(input logic l, input logic r);
        gs_if.btn_left_n  = ~l;
        gs_if.btn_right_n = ~r;
        next();
        gs_if.btn_left_n  = 1'b1;
        gs_if.btn_right_n = 1'b1;
        run_tick();
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        reset  = 1'b1;
        gs_if.btn_left_n  = 1'b1;
        gs_if.btn_right_n = 1'b1;
        gs_if.enemy_alive = 6'b111111;
        gs_if.hit         = 1'b0;

        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = 1;
        check("rst_tick",  {31'd0, gs_if.tick}, 32'd0);
        check("rst_phase", {30'd0, gs_if.phase}, 32'd0);
        check("rst_play",  {31'd0, gs_if.play_en}, 32'd0);
        check("rst_pos",   {28'd0, gs_if.player_pos}, 32'd3);
        check("rst_ephase",{31'd0, gs_if.enemy_phase}, 32'd0);
        check("rst_exp",   {31'd0, gs_if.explode_active}, 32'd0);
        check("rst_frame", {30'd0, gs_if.explode_frame}, 32'd0);
        check("rst_blink", {31'd0, gs_if.win_blink}, 32'd1);

        // Ticks on cycles 4,8,12,16,20; PLAY from cycle 17.
        for (int c = 2; c <= 20; c++) begin
            next();
            check("tick_seq",  {31'd0, gs_if.tick}, (c % 4 == 0) ? 32'd1 : 32'd0);
            check("phase_seq", {30'd0, gs_if.phase}, (c >= 17) ? 32'd1 : 32'd0);
            check("play_seq",  {31'd0, gs_if.play_en}, (c >= 17) ? 32'd1 : 32'd0);
        end
        next();
        check("ephase_t20", {31'd0, gs_if.enemy_phase}, 32'd1);

        press(1'b0, 1'b1);
        check("step_right", {28'd0, gs_if.player_pos}, 32'd4);
        check("ephase_t24", {31'd0, gs_if.enemy_phase}, 32'd0);
        run_tick();
        check("no_2nd_step", {28'd0, gs_if.player_pos}, 32'd4);
        check("ephase_t28", {31'd0, gs_if.enemy_phase}, 32'd1);

        // Press that first shows up in the tick cycle waits for the following tick.
        next();
        gs_if.btn_right_n = 1'b0;
        next();
        gs_if.btn_right_n = 1'b1;
        run_tick();
        check("late_press_held", {28'd0, gs_if.player_pos}, 32'd4);
        run_tick();
        check("late_press_used", {28'd0, gs_if.player_pos}, 32'd5);
        check("ephase_t36", {31'd0, gs_if.enemy_phase}, 32'd1);

`ifdef GAME_SEQUENCER_PAUSE_EN
        press(1'b1, 1'b1);
        check("pause_phase", {30'd0, gs_if.phase}, 32'd3);
        check("pause_play",  {31'd0, gs_if.play_en}, 32'd0);
        check("pause_pos",   {28'd0, gs_if.player_pos}, 32'd5);
        for (int i = 0; i < 5; i++) begin
            run_tick();
            check("pause_hold",   {30'd0, gs_if.phase}, 32'd3);
            check("pause_ephase", {31'd0, gs_if.enemy_phase}, 32'd1);
        end
        press(1'b1, 1'b1);
        check("resume_phase", {30'd0, gs_if.phase}, 32'd1);
        check("resume_pos",   {28'd0, gs_if.player_pos}, 32'd5);
        press(1'b0, 1'b1);
`else
        press(1'b1, 1'b1);
`endif
        check("both_pos6",   {28'd0, gs_if.player_pos}, 32'd6);
        check("both_ephase", {31'd0, gs_if.enemy_phase}, 32'd0);

        for (int i = 0; i < 5; i++) press(1'b0, 1'b1);
        check("walk_r11", {28'd0, gs_if.player_pos}, 32'd11);
        press(1'b0, 1'b1);
        check("bound_r11", {28'd0, gs_if.player_pos}, 32'd11);
`ifndef GAME_SEQUENCER_PAUSE_EN
        press(1'b1, 1'b1);
        check("bound_both11", {28'd0, gs_if.player_pos}, 32'd11);
`endif
        for (int i = 0; i < 11; i++) press(1'b1, 1'b0);
        check("walk_l0", {28'd0, gs_if.player_pos}, 32'd0);
        press(1'b1, 1'b0);
        check("bound_l0", {28'd0, gs_if.player_pos}, 32'd0);

        gs_if.hit = 1'b1;
        next();
        gs_if.hit = 1'b0;
        check("hit_act",  {31'd0, gs_if.explode_active}, 32'd1);
        check("hit_f0",   {30'd0, gs_if.explode_frame}, 32'd0);
        run_tick();
        check("exp_f1",   {30'd0, gs_if.explode_frame}, 32'd1);
        run_tick();
        check("exp_f2",   {30'd0, gs_if.explode_frame}, 32'd2);
        check("exp_act2", {31'd0, gs_if.explode_active}, 32'd1);
        run_tick();
        check("exp_done", {31'd0, gs_if.explode_active}, 32'd0);
        check("exp_f_rst",{30'd0, gs_if.explode_frame}, 32'd0);

        gs_if.hit = 1'b1;
        next();
        gs_if.hit = 1'b0;
        run_tick();
        check("exp2_f1", {30'd0, gs_if.explode_frame}, 32'd1);
        next();
        next();
        next();
        check("pre_hit_tick", {31'd0, gs_if.tick}, 32'd1);
        gs_if.hit = 1'b1;
        next();
        gs_if.hit = 1'b0;
        check("hit_tick_f0",  {30'd0, gs_if.explode_frame}, 32'd0);
        check("hit_tick_act", {31'd0, gs_if.explode_active}, 32'd1);

        gs_if.enemy_alive = 6'b000000;
        run_tick();
        check("win_phase", {30'd0, gs_if.phase}, 32'd2);
        check("win_play",  {31'd0, gs_if.play_en}, 32'd0);
        check("win_pos",   {28'd0, gs_if.player_pos}, 32'd0);
        check("win_blink0",{31'd0, gs_if.win_blink}, 32'd1);
        check("win_exp_f1",{30'd0, gs_if.explode_frame}, 32'd1);
        run_tick();
        check("win_blink1",{31'd0, gs_if.win_blink}, 32'd0);
        check("win_exp_f2",{30'd0, gs_if.explode_frame}, 32'd2);
        run_tick();
        check("win_blink2",{31'd0, gs_if.win_blink}, 32'd1);
        check("win_exp_end",{31'd0, gs_if.explode_active}, 32'd0);
        press(1'b0, 1'b1);
        check("win_pos_frz",{28'd0, gs_if.player_pos}, 32'd0);
        check("win_stay",   {30'd0, gs_if.phase}, 32'd2);
        check("win_blink3", {31'd0, gs_if.win_blink}, 32'd0);
        gs_if.hit = 1'b1;
        next();
        gs_if.hit = 1'b0;
        check("win_hit_ign",{31'd0, gs_if.explode_active}, 32'd0);

        reset = 1'b1;
        next();
        reset = 1'b0;
        gs_if.enemy_alive = 6'b111111;
        cyc = 1;
        check("rst2_phase", {30'd0, gs_if.phase}, 32'd0);
        check("rst2_pos",   {28'd0, gs_if.player_pos}, 32'd3);
        check("rst2_blink", {31'd0, gs_if.win_blink}, 32'd1);
        check("rst2_tick",  {31'd0, gs_if.tick}, 32'd0);
        next();
        next();
        check("rst2_c3_tick", {31'd0, gs_if.tick}, 32'd0);
        next();
        check("rst2_c4_tick", {31'd0, gs_if.tick}, 32'd1);
        next();
        check("rst2_cd_phase", {30'd0, gs_if.phase}, 32'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
Central sequencer for the VGA shooter game. It derives the game tick from CLK_50, runs the phase FSM (countdown, play, win), and latches button presses so that none are lost between ticks. It owns the player column and the explosion animation timer, and issues one-cycle strobes to the game datapath. The render and bullet logic consume its outputs only; they no longer contain their own timing.

Parameters:
TICK_DIV, 20000000, CLK_50 cycles per game tick (>=2)
START_TICKS, 3, ticks spent in COUNTDOWN after reset
EXPLODE_TICKS, 3, animation frames per explosion (>=1, <=4)
ENEMY_COUNT, 6, enemies; player columns 0..2*ENEMY_COUNT-1
PLAYER_START, 3, player column after reset

Ports:
CLK_50  in  1  system clock, 50 MHz
reset  in  1  synchronous, active-high
btn_left_n  in  1  raw left button, active-low, asynchronous to CLK_50
btn_right_n  in  1  raw right button, active-low, asynchronous to CLK_50
enemy_alive  in  ENEMY_COUNT  per-enemy alive flags from datapath
hit  in  1  one-cycle pulse from datapath: live enemy destroyed
tick  out  1  one-cycle game tick pulse
phase  out  2  0=COUNTDOWN, 1=PLAY, 2=WIN, 3=PAUSE
play_en  out  1  high while phase==PLAY
player_pos  out  4  player column
enemy_phase  out  1  enemy row offset, toggles each PLAY tick
explode_active  out  1  explosion animation running
explode_frame  out  2  current explosion frame
win_blink  out  1  end-screen visibility, toggles each WIN tick

Behaviour:
- Reset: all state updates on the CLK_50 edge where reset=1. Reset values:
  - tick=0, phase=COUNTDOWN, play_en=0, player_pos=PLAYER_START, enemy_phase=0
  - explode_active=0, explode_frame=0, win_blink=1
  - tick counter=0, countdown counter=START_TICKS, button flags=0, synchronizers=1
- Reset mid-operation: aborts any phase, including an explosion, on the same edge.
- Tick divider:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly the cycle the counter equals TICK_DIV-1.
  - First tick after reset release falls on cycle TICK_DIV (cycle 1 = first cycle with reset=0).
- Buttons:
  - Each raw input goes through a 2-flop synchronizer (reset value 1).
  - A sticky request flag (req_l, req_r) sets on any cycle the synchronized input is 0.
  - Both flags clear on the tick cycle, after being sampled.
  - A flag setting in the tick cycle itself is kept for the next tick.
- FSM, evaluated only on tick cycles:
  - COUNTDOWN: decrement the countdown counter. When it is 0 at a tick, go to PLAY. No strobes; button flags are discarded.
  - PLAY, checked in this order:
    - If enemy_alive==0, go to WIN; no movement that tick.
    - Otherwise toggle enemy_phase.
    - If req_r and player_pos!=2*ENEMY_COUNT-1, then player_pos+1.
    - Else if req_l and player_pos!=0, then player_pos-1.
    - Right has priority over left. A request at the boundary is dropped and the other direction is not substituted.
  - WIN: toggle win_blink each tick. Stays in WIN until reset.
- play_en is registered together with phase.
- Explosion timer:
  - hit while play_en=1 sets explode_active=1 and explode_frame=0.
  - On a tick with explode_active=1: if explode_frame==EXPLODE_TICKS-1, clear explode_active and return explode_frame to 0; otherwise explode_frame+1.
  - hit and tick in the same cycle: hit wins (frame 0, no advance).
  - hit while already active restarts at frame 0.
  - hit outside PLAY is ignored.
  - A running explosion continues to completion after the transition to WIN.
- Arithmetic: player_pos is 4-bit unsigned and never wraps. Bounds are checked before each step.

Optional Feature:
- Macro: GAME_SEQUENCER_PAUSE_EN.
- When defined:
  - In PLAY, a tick with req_l and req_r both set goes to PAUSE. No movement, enemy_phase and explosion frozen, play_en=0.
  - In PAUSE, a tick with both set returns to PLAY. All other ticks are ignored.
  - The enemy_alive==0 check takes precedence over pause.
- When undefined:
  - PAUSE is unreachable.
  - Both flags set behaves as right-only.

Test Plan:
- TICK_DIV=4, START_TICKS=3; release reset at cycle 0 -> tick on cycles 4, 8, 12, 16; phase=PLAY from cycle 17; play_en=1 from cycle 17.
- In PLAY at pos 3, pulse btn_right_n low for 1 cycle mid-interval -> pos 4 at next tick only; no second step on the following tick.
- Right+left held at pos 11 (ENEMY_COUNT=6) -> pos stays 11, no left step; left only at pos 0 -> pos stays 0.
- hit in PLAY with EXPLODE_TICKS=3 -> frames 0, 1, 2 across ticks, explode_active drops at third tick; hit coincident with tick -> frame 0.
- enemy_alive=0 during PLAY -> WIN at next tick, player_pos frozen, win_blink toggles 1->0->1 on successive ticks; reset asserted -> COUNTDOWN, pos 3.
- PAUSE_EN defined: both buttons at a tick -> phase=3, enemy_phase frozen for 5 ticks, both again -> PLAY; undefined: same stimulus -> pos+1.
